// File: rtl/writeback_unit.sv
// writeback_unit: per-lane result select, load-beat gather, youngest-wins write resolve.
// Optional WB_SUBWORD_LOAD_EN: byte/half extraction and extension of load data.
module writeback_unit #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [LANES-1:0]      regwrite_i,
  input  logic [2*LANES-1:0]    wb_sel_i,
  input  logic [5*LANES-1:0]    rd_addr_i,
  input  logic [XLEN*LANES-1:0] alu_out_i,
  input  logic [XLEN*LANES-1:0] pc_i,
  input  logic [3*LANES-1:0]    ld_fmt_i,
  input  logic [2*LANES-1:0]    ld_off_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [XLEN-1:0]       ld_data_i,
  output logic                  wb_valid_o,
  output logic [LANES-1:0]      rd_we_o,
  output logic [5*LANES-1:0]    rd_addr_o,
  output logic [XLEN*LANES-1:0] rd_data_o
);

  typedef enum logic {IDLE, WAIT_LD} state_e;

  state_e                state_q;
  logic [2:0]            pend_q;
  logic [LANES-1:0]      rw_q;
  logic [LANES-1:0]      fill_q;
  logic [2*LANES-1:0]    sel_q;
  logic [5*LANES-1:0]    rd_q;
  logic [XLEN*LANES-1:0] alu_q;
  logic [XLEN*LANES-1:0] pc_q;
  logic [XLEN*LANES-1:0] ld_q;
  logic                  wbv_q;
  logic [LANES-1:0]      we_q;
  logic [5*LANES-1:0]    addr_q;
  logic [XLEN*LANES-1:0] data_q;

  logic                  idle;
  logic [LANES-1:0]      s_rw;
  logic [LANES-1:0]      ldm_in;
  logic [LANES-1:0]      ldm_cap;
  logic [LANES-1:0]      slot;
  logic [LANES-1:0]      we_d;
  logic [2*LANES-1:0]    s_sel;
  logic [5*LANES-1:0]    s_rd;
  logic [XLEN*LANES-1:0] s_alu;
  logic [XLEN*LANES-1:0] s_pc;
  logic [XLEN*LANES-1:0] s_ld;
  logic [XLEN*LANES-1:0] data_d;
  logic [2:0]            cnt;
  logic                  found;
  logic [XLEN-1:0]       v;

`ifdef WB_SUBWORD_LOAD_EN
  logic [3*LANES-1:0] fmt_q;
  logic [3*LANES-1:0] s_fmt;
  logic [2*LANES-1:0] off_q;
  logic [2*LANES-1:0] s_off;

  function automatic logic [XLEN-1:0] ld_ext(
    input logic [XLEN-1:0] raw,
    input logic [2:0]      fmt,
    input logic [1:0]      off
  );
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] h;
    b = raw >> {off, 3'b000};
    h = raw >> {off[1], 4'b0000};
    case (fmt)
      3'b000:  ld_ext = {{(XLEN-8){b[7]}}, b[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){h[15]}}, h[15:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, b[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, h[15:0]};
      default: ld_ext = raw;
    endcase
  endfunction
`else
  logic unused_ld;
  assign unused_ld = ^{ld_fmt_i, ld_off_i};
`endif

  assign idle       = (state_q == IDLE);
  assign ready_o    = idle;
  assign ld_ready_o = !idle;
  assign wb_valid_o = wbv_q;
  assign rd_we_o    = we_q;
  assign rd_addr_o  = addr_q;
  assign rd_data_o  = data_q;

  // In IDLE the commit path sees the incoming bundle, otherwise the captured one.
  always_comb begin
    s_rw  = idle ? regwrite_i : rw_q;
    s_sel = idle ? wb_sel_i   : sel_q;
    s_rd  = idle ? rd_addr_i  : rd_q;
    s_alu = idle ? alu_out_i  : alu_q;
    s_pc  = idle ? pc_i       : pc_q;
`ifdef WB_SUBWORD_LOAD_EN
    s_fmt = idle ? ld_fmt_i   : fmt_q;
    s_off = idle ? ld_off_i   : off_q;
`endif
    cnt   = '0;
    found = 1'b0;
    slot  = '0;
    for (int i = 0; i < LANES; i++) begin
      ldm_in[i]  = regwrite_i[i] && (wb_sel_i[2*i+:2] == 2'b10);
      ldm_cap[i] = rw_q[i] && (sel_q[2*i+:2] == 2'b10);
      cnt        = cnt + 3'(ldm_in[i]);
      if (ldm_cap[i] && !fill_q[i] && !found) begin
        slot[i] = 1'b1;
        found   = 1'b1;
      end
    end
    s_ld = ld_q;
    for (int i = 0; i < LANES; i++)
      if (slot[i]) s_ld[i*XLEN+:XLEN] = ld_data_i;
    we_d   = '0;
    data_d = '0;
    v      = '0;
    for (int i = 0; i < LANES; i++) begin
      we_d[i] = s_rw[i] && (s_rd[5*i+:5] != 5'd0);
      for (int j = 0; j < LANES; j++)
        if (j > i && s_rw[j] && s_rd[5*j+:5] == s_rd[5*i+:5])
          we_d[i] = 1'b0;
      case (s_sel[2*i+:2])
        2'b00:   v = s_alu[i*XLEN+:XLEN];
        2'b01:   v = s_pc[i*XLEN+:XLEN] + XLEN'(4);
`ifdef WB_SUBWORD_LOAD_EN
        2'b10:   v = ld_ext(s_ld[i*XLEN+:XLEN], s_fmt[3*i+:3], s_off[2*i+:2]);
`else
        2'b10:   v = s_ld[i*XLEN+:XLEN];
`endif
        default: v = '0;
      endcase
      if (we_d[i]) data_d[i*XLEN+:XLEN] = v;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      rw_q    <= '0;
      fill_q  <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      pc_q    <= '0;
      ld_q    <= '0;
      wbv_q   <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef WB_SUBWORD_LOAD_EN
      fmt_q   <= '0;
      off_q   <= '0;
`endif
    end else begin
      wbv_q <= 1'b0;
      if (flush_i) begin
        state_q <= IDLE;
        pend_q  <= '0;
        rw_q    <= '0;
        fill_q  <= '0;
        we_q    <= '0;
        data_q  <= '0;
      end else if (idle && valid_i) begin
        rw_q   <= regwrite_i;
        sel_q  <= wb_sel_i;
        rd_q   <= rd_addr_i;
        alu_q  <= alu_out_i;
        pc_q   <= pc_i;
        fill_q <= '0;
`ifdef WB_SUBWORD_LOAD_EN
        fmt_q  <= ld_fmt_i;
        off_q  <= ld_off_i;
`endif
        if (cnt == 3'd0) begin
          wbv_q  <= 1'b1;
          we_q   <= we_d;
          addr_q <= s_rd;
          data_q <= data_d;
        end else begin
          state_q <= WAIT_LD;
          pend_q  <= cnt;
        end
      end else if (!idle && ld_valid_i) begin
        ld_q   <= s_ld;
        fill_q <= fill_q | slot;
        pend_q <= pend_q - 3'd1;
        if (pend_q == 3'd1) begin
          state_q <= IDLE;
          wbv_q   <= 1'b1;
          we_q    <= we_d;
          addr_q  <= s_rd;
          data_q  <= data_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and randomized bundles checked against
// a lane-level reference model of the writeback rules.
module tb_writeback_unit;

  localparam int L = 2;
`ifdef WB_SUBWORD_LOAD_EN
  localparam bit SUBW = 1'b1;
`else
  localparam bit SUBW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          valid;
  logic          ready;
  logic [L-1:0]  rw;
  logic [2*L-1:0] sel;
  logic [5*L-1:0] rd;
  logic [32*L-1:0] alu;
  logic [32*L-1:0] pc;
  logic [3*L-1:0] fmt;
  logic [2*L-1:0] off;
  logic          ldv;
  logic          ldr;
  logic [31:0]   ldd;
  logic          wbv;
  logic [L-1:0]  we;
  logic [5*L-1:0] addr;
  logic [32*L-1:0] data;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  bit          b_rw[L];
  logic [1:0]  b_sel[L];
  logic [4:0]  b_rd[L];
  logic [31:0] b_alu[L];
  logic [31:0] b_pc[L];
  logic [31:0] b_ld[L];
  logic [2:0]  b_fmt[L];
  logic [1:0]  b_off[L];

  writeback_unit #(.LANES(L), .XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(valid), .ready_o(ready),
    .regwrite_i(rw), .wb_sel_i(sel), .rd_addr_i(rd),
    .alu_out_i(alu), .pc_i(pc), .ld_fmt_i(fmt), .ld_off_i(off),
    .ld_valid_i(ldv), .ld_ready_o(ldr), .ld_data_i(ldd),
    .wb_valid_o(wbv), .rd_we_o(we), .rd_addr_o(addr),
    .rd_data_o(data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ldval(input logic [31:0] raw,
                                        input int f, input int o);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (8 * o)) & 32'hFF;
    h = (raw >> (16 * (o / 2))) & 32'hFFFF;
    if (!SUBW) return raw;
    case (f)
      0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      1: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      4: return b;
      5: return h;
      default: return raw;
    endcase
  endfunction

  function automatic void model(output logic [L-1:0] ew,
                                output logic [32*L-1:0] ed,
                                output logic [5*L-1:0] ea);
    logic [31:0] val;
    bit w;
    ew = '0;
    ed = '0;
    ea = '0;
    for (int i = 0; i < L; i++) begin
      w = b_rw[i] && b_rd[i] != 0;
      for (int j = i + 1; j < L; j++)
        if (b_rw[j] && b_rd[j] == b_rd[i]) w = 0;
      case (b_sel[i])
        2'd0: val = b_alu[i];
        2'd1: val = b_pc[i] + 32'd4;
        2'd2: val = ldval(b_ld[i], int'(b_fmt[i]), int'(b_off[i]));
        default: val = 32'd0;
      endcase
      ew[i] = w;
      if (w) ed[32*i+:32] = val;
      ea[5*i+:5] = b_rd[i];
    end
  endfunction

  task automatic lane(input int i, input bit w, input logic [1:0] s,
                      input logic [4:0] r, input logic [31:0] a,
                      input logic [31:0] p, input logic [31:0] ld,
                      input logic [2:0] f, input logic [1:0] o);
    b_rw[i] = w; b_sel[i] = s; b_rd[i] = r; b_alu[i] = a;
    b_pc[i] = p; b_ld[i] = ld; b_fmt[i] = f; b_off[i] = o;
  endtask

  task automatic pack();
    for (int i = 0; i < L; i++) begin
      rw[i]         = b_rw[i];
      sel[2*i+:2]   = b_sel[i];
      rd[5*i+:5]    = b_rd[i];
      alu[32*i+:32] = b_alu[i];
      pc[32*i+:32]  = b_pc[i];
      fmt[3*i+:3]   = b_fmt[i];
      off[2*i+:2]   = b_off[i];
    end
  endtask

  // gap < 0 picks a random 0..2 idle cycles before each beat.
  task automatic run_bundle(input string tag, input int gap);
    logic [L-1:0] ew;
    logic [32*L-1:0] ed;
    logic [5*L-1:0] ea;
    int g;
    bit any_ld;
    model(ew, ed, ea);
    pack();
    valid = 1'b1;
    step();
    valid = 1'b0;
    any_ld = 0;
    for (int i = 0; i < L; i++)
      if (b_rw[i] && b_sel[i] == 2'd2) begin
        if (!any_ld) chk({tag, "_ldr"}, 128'(ldr), 128'(1));
        any_ld = 1;
        g = (gap < 0) ? $urandom_range(0, 2) : gap;
        for (int k = 0; k < g; k++) begin
          chk({tag, "_rdy_wait"}, 128'(ready), 128'(0));
          step();
        end
        chk({tag, "_rdy_beat"}, 128'(ready), 128'(0));
        ldv = 1'b1;
        ldd = b_ld[i];
        step();
        ldv = 1'b0;
        ldd = $urandom;
      end
    chk({tag, "_wbv"}, 128'(wbv), 128'(1));
    chk({tag, "_we"}, 128'(we), 128'(ew));
    chk({tag, "_addr"}, 128'(addr), 128'(ea));
    chk({tag, "_data"}, 128'(data), 128'(ed));
    chk({tag, "_rdy"}, 128'(ready), 128'(1));
    step();
    chk({tag, "_pulse"}, 128'(wbv), 128'(0));
  endtask

  task automatic two_load_one_beat();
    lane(0, 1, 2'd2, 5'd10, 0, 0, 32'hAAAA, 3'd2, 2'd0);
    lane(1, 1, 2'd2, 5'd11, 0, 0, 32'hBBBB, 3'd2, 2'd0);
    pack();
    valid = 1'b1;
    step();
    valid = 1'b0;
    ldv = 1'b1;
    ldd = 32'h5151;
    step();
    ldv = 1'b0;
  endtask

  int fm[6] = '{0, 1, 2, 4, 5, 3};

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ldv = 1'b0; ldd = '0;
    rw = '0; sel = '0; rd = '0; alu = '0; pc = '0; fmt = '0; off = '0;
    #1;
    chk("rst_rdy", 128'(ready), 128'(1));
    chk("rst_ldr", 128'(ldr), 128'(0));
    chk("rst_out", 128'({wbv, we, addr, data}), 128'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    lane(0, 1, 2'd0, 5'd5, 32'h1234, 32'h0, 0, 3'd2, 2'd0);
    lane(1, 1, 2'd1, 5'd6, 32'h9999, 32'h80, 0, 3'd2, 2'd0);
    run_bundle("alupc", 0);
    chk("alupc_const", 128'(data), 128'({32'h84, 32'h1234}));
    chk("alupc_we", 128'(we), 128'(2'b11));

    lane(0, 1, 2'd0, 5'd7, 32'hA, 0, 0, 3'd2, 2'd0);
    lane(1, 1, 2'd0, 5'd7, 32'hB, 0, 0, 3'd2, 2'd0);
    run_bundle("conflict", 0);
    chk("conflict_we", 128'(we), 128'(2'b10));
    chk("conflict_d", 128'(data), 128'({32'hB, 32'h0}));

    lane(0, 1, 2'd0, 5'd0, 32'h55, 0, 0, 3'd2, 2'd0);
    lane(1, 1, 2'd0, 5'd3, 32'h66, 0, 0, 3'd2, 2'd0);
    run_bundle("x0", 0);
    chk("x0_we", 128'(we), 128'(2'b10));
    chk("x0_d0", 128'(data[31:0]), 128'(0));

    lane(0, 1, 2'd1, 5'd1, 0, 32'hFFFFFFFC, 0, 3'd2, 2'd0);
    lane(1, 0, 2'd0, 5'd2, 0, 0, 0, 3'd2, 2'd0);
    run_bundle("pcwrap", 0);
    chk("pcwrap_d", 128'(data[31:0]), 128'(0));

    lane(0, 1, 2'd2, 5'd12, 0, 0, 32'h11, 3'd2, 2'd0);
    lane(1, 1, 2'd2, 5'd13, 0, 0, 32'h22, 3'd2, 2'd0);
    run_bundle("twold", 1);
    chk("twold_d", 128'(data), 128'({32'h22, 32'h11}));

    lane(0, 1, 2'd2, 5'd9, 0, 0, 32'h80FFFFFF, 3'd0, 2'd3);
    lane(1, 0, 2'd0, 5'd0, 0, 0, 0, 3'd2, 2'd0);
    run_bundle("lb", 0);
    chk("lb_const", 128'(data[31:0]),
        128'(SUBW ? 32'hFFFFFF80 : 32'h80FFFFFF));

    lane(0, 1, 2'd2, 5'd9, 0, 0, 32'hBEEF0000, 3'd5, 2'd2);
    run_bundle("lhu", 0);
    chk("lhu_const", 128'(data[31:0]),
        128'(SUBW ? 32'h0000BEEF : 32'hBEEF0000));

    // back-to-back non-load bundles
    lane(0, 1, 2'd0, 5'd20, 32'h100, 0, 0, 3'd2, 2'd0);
    lane(1, 1, 2'd0, 5'd21, 32'h200, 0, 0, 3'd2, 2'd0);
    pack();
    valid = 1'b1;
    step();
    chk("b2b_v0", 128'(wbv), 128'(1));
    chk("b2b_d0", 128'(data), 128'({32'h200, 32'h100}));
    lane(0, 1, 2'd0, 5'd22, 32'h300, 0, 0, 3'd2, 2'd0);
    lane(1, 1, 2'd0, 5'd23, 32'h400, 0, 0, 3'd2, 2'd0);
    pack();
    step();
    valid = 1'b0;
    chk("b2b_v1", 128'(wbv), 128'(1));
    chk("b2b_d1", 128'(data), 128'({32'h400, 32'h300}));
    step();
    chk("b2b_end", 128'(wbv), 128'(0));

    two_load_one_beat();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_wbv", 128'(wbv), 128'(0));
    chk("flush_we", 128'(we), 128'(0));
    chk("flush_rdy", 128'(ready), 128'(1));
    ldv = 1'b1;
    ldd = 32'h7777;
    step();
    ldv = 1'b0;
    chk("flush_late", 128'({wbv, we}), 128'(0));

    lane(0, 1, 2'd0, 5'd5, 32'h1234, 0, 0, 3'd2, 2'd0);
    lane(1, 1, 2'd1, 5'd6, 0, 32'h80, 0, 3'd2, 2'd0);
    run_bundle("pre_rst", 0);
    two_load_one_beat();
    rst_n = 1'b0;
    #1;
    chk("mrst_out", 128'({wbv, we, addr, data}), 128'(0));
    chk("mrst_rdy", 128'(ready), 128'(1));
    chk("mrst_ldr", 128'(ldr), 128'(0));
    step();
    rst_n = 1'b1;
    ldv = 1'b1;
    ldd = 32'h4242;
    step();
    ldv = 1'b0;
    chk("mrst_ign", 128'({wbv, we, data}), 128'(0));
    chk("mrst_rdy2", 128'(ready), 128'(1));

    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < L; i++)
        lane(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom,
             ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & ~32'h3),
             $urandom, 3'(fm[$urandom_range(0, 5)]),
             2'($urandom_range(0, 3)));
      run_bundle("rand", -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
